// File: rtl/cam_seq.sv
// Camera bring-up sequencer and frame-aligned pixel streamer for the 125 MHz system domain.
// Optional watchdog on the wait states is built when SEQ_TIMEOUT_EN is defined.
module cam_seq #(
  parameter int unsigned POWERUP_CYCLES = 1250000,
  parameter int unsigned FRAME_SKIP     = 2,
  parameter int unsigned FRAME_PIXELS   = 307200,
  parameter int unsigned TIMEOUT_CYCLES = 12500000
) (
  input  logic        i_clk,
  input  logic        i_rstn,
  input  logic        i_enable,
  output logic        o_cfg_init,
  input  logic        i_cfg_done,
  input  logic        i_sof,
  input  logic        i_obuf_empty,
  output logic        o_obuf_rd,
  input  logic [15:0] i_obuf_data,
  output logic        o_pix_valid,
  input  logic        i_pix_ready,
  output logic [15:0] o_pix_data,
  output logic        o_pix_sof,
  output logic        o_pix_eof,
  output logic        o_frame_err,
  output logic [2:0]  o_state,
  output logic        o_timeout
);

  localparam int unsigned PwrW  = (POWERUP_CYCLES > 1) ? $clog2(POWERUP_CYCLES + 1) : 1;
  localparam int unsigned SkipW = (FRAME_SKIP > 1) ? $clog2(FRAME_SKIP + 1) : 1;
  localparam int unsigned CntW  = $clog2(FRAME_PIXELS + 1);
  localparam logic [CntW-1:0] PixFull = CntW'(FRAME_PIXELS);
  localparam logic [CntW-1:0] PixLast = CntW'(FRAME_PIXELS - 1);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    PWRUP    = 3'd1,
    CFG      = 3'd2,
    CFG_WAIT = 3'd3,
    SKIP     = 3'd4,
    ALIGN    = 3'd5,
    STREAM   = 3'd6
  } state_e;

  state_e            stateQ, stateD;
  logic [PwrW-1:0]   pwrCntQ, pwrCntD;
  logic [SkipW-1:0]  skipCntQ, skipCntD;
  logic [CntW-1:0]   pixCntQ, pixCntD;
  logic              pendQ, pendD;
  logic              validQ, validD;
  logic [15:0]       dataQ, dataD;
  logic              sofQ, sofD;
  logic              eofQ, eofD;
  logic              errQ, errD;
  logic              longErrQ, longErrD;
  logic [2:0]        sofSyncQ;
  logic              sofEvt;
  logic              slotFree;
  logic              obufRd;
  logic [CntW-1:0]   cntEff;

  // Bits 0/1 synchronise the pclk-domain pulse; bit 2 is the delayed copy for edge detect.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      sofSyncQ <= '0;
    end else begin
      sofSyncQ <= {sofSyncQ[1:0], i_sof};
    end
  end

  assign sofEvt   = sofSyncQ[1] & ~sofSyncQ[2];
  assign slotFree = !validQ || i_pix_ready;

`ifdef SEQ_TIMEOUT_EN
  localparam int unsigned WdogW = $clog2(TIMEOUT_CYCLES + 1);
  logic [WdogW-1:0] wdogQ, wdogD;
  logic             timeoutQ, timeoutD;
  logic             inWait;
`endif

  always_comb begin
    stateD   = stateQ;
    pwrCntD  = pwrCntQ;
    skipCntD = skipCntQ;
    pixCntD  = pixCntQ;
    pendD    = 1'b0;
    validD   = validQ;
    dataD    = dataQ;
    sofD     = sofQ;
    eofD     = eofQ;
    errD     = 1'b0;
    longErrD = longErrQ;
    obufRd   = 1'b0;
    cntEff   = pixCntQ;
`ifdef SEQ_TIMEOUT_EN
    wdogD    = '0;
    timeoutD = timeoutQ;
    inWait   = 1'b0;
`endif

    unique case (stateQ)
      IDLE: begin
        if (i_enable) stateD = PWRUP;
      end
      PWRUP: begin
        pwrCntD = pwrCntQ + 1'b1;
        if ((32'(pwrCntQ) + 32'd1) >= POWERUP_CYCLES) begin
          stateD  = CFG;
          pwrCntD = '0;
        end
      end
      CFG: begin
        stateD = CFG_WAIT;
      end
      CFG_WAIT: begin
        if (i_cfg_done) stateD = (FRAME_SKIP == 0) ? ALIGN : SKIP;
      end
      SKIP: begin
        obufRd = !i_obuf_empty;
        if (sofEvt) begin
          if ((32'(skipCntQ) + 32'd1) >= FRAME_SKIP) begin
            stateD   = ALIGN;
            skipCntD = '0;
          end else begin
            skipCntD = skipCntQ + 1'b1;
          end
        end
      end
      ALIGN: begin
        obufRd = !i_obuf_empty;
        if (sofEvt) begin
          stateD   = STREAM;
          pixCntD  = '0;
          longErrD = 1'b0;
        end
      end
      STREAM: begin
        obufRd = !i_obuf_empty && !pendQ && slotFree;
        pendD  = obufRd;
        if (validQ && i_pix_ready) validD = 1'b0;
        // A frame marker is applied before any same-cycle load so that pixel becomes index 0.
        if (sofEvt) begin
          if (pixCntQ != '0 && pixCntQ != PixFull) errD = 1'b1;
          cntEff   = '0;
          longErrD = 1'b0;
        end
        if (pendQ) begin
          if (cntEff == PixFull) begin
            if (!longErrQ) errD = 1'b1;
            longErrD = 1'b1;
          end else begin
            dataD  = i_obuf_data;
            sofD   = (cntEff == '0);
            eofD   = (cntEff == PixLast);
            validD = 1'b1;
            cntEff = cntEff + 1'b1;
          end
        end
        pixCntD = cntEff;
      end
      default: begin
        stateD = IDLE;
      end
    endcase

`ifdef SEQ_TIMEOUT_EN
    inWait = (stateQ == CFG_WAIT) || (stateQ == SKIP) || (stateQ == ALIGN);
    if (inWait && stateD == stateQ && !sofEvt) begin
      if ((32'(wdogQ) + 32'd1) >= TIMEOUT_CYCLES) begin
        stateD   = PWRUP;
        timeoutD = 1'b1;
        skipCntD = '0;
      end else begin
        wdogD = wdogQ + 1'b1;
      end
    end
`endif

    // Dropping enable abandons everything, including a read whose data is still in flight.
    if (!i_enable && stateQ != IDLE) begin
      stateD   = IDLE;
      validD   = 1'b0;
      pendD    = 1'b0;
      pwrCntD  = '0;
      skipCntD = '0;
    end
  end

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      stateQ   <= IDLE;
      pwrCntQ  <= '0;
      skipCntQ <= '0;
      pixCntQ  <= '0;
      pendQ    <= 1'b0;
      validQ   <= 1'b0;
      dataQ    <= '0;
      sofQ     <= 1'b0;
      eofQ     <= 1'b0;
      errQ     <= 1'b0;
      longErrQ <= 1'b0;
    end else begin
      stateQ   <= stateD;
      pwrCntQ  <= pwrCntD;
      skipCntQ <= skipCntD;
      pixCntQ  <= pixCntD;
      pendQ    <= pendD;
      validQ   <= validD;
      dataQ    <= dataD;
      sofQ     <= sofD;
      eofQ     <= eofD;
      errQ     <= errD;
      longErrQ <= longErrD;
    end
  end

`ifdef SEQ_TIMEOUT_EN
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      wdogQ    <= '0;
      timeoutQ <= 1'b0;
    end else begin
      wdogQ    <= wdogD;
      timeoutQ <= timeoutD;
    end
  end
  assign o_timeout = timeoutQ;
`else
  assign o_timeout = 1'b0;
`endif

  assign o_cfg_init  = (stateQ == CFG);
  assign o_obuf_rd   = obufRd;
  assign o_pix_valid = validQ;
  assign o_pix_data  = dataQ;
  assign o_pix_sof   = sofQ;
  assign o_pix_eof   = eofQ;
  assign o_frame_err = errQ;
  assign o_state     = stateQ;

endmodule

// File: doc/cam_seq.md
Name: cam_seq

Overview:
- Top-level sequencer for the camera block, running in the single 125 MHz system domain.
- Brings the camera up in order: power-up delay, register configuration, then discards the first few settling frames.
- Then drains the output buffer FIFO into a frame-aligned valid/ready pixel stream, with start-of-frame (SOF) and end-of-frame (EOF) markers and frame-length checking.
- Sits between the camera top block (configuration start/done, output FIFO read port, SOF flag) and downstream frame-buffer/colour-detect logic.

Parameters:
- POWERUP_CYCLES, 1250000, i_clk cycles waited after enable before configuration starts (10 ms at 125 MHz).
- FRAME_SKIP, 2, number of complete frames discarded after configuration done.
- FRAME_PIXELS, 307200, 16-bit pixels per frame (640x480).
- TIMEOUT_CYCLES, 12500000, watchdog limit; used only with SEQ_TIMEOUT_EN.

Ports:
- i_clk  in  1  system clock (125 MHz); also the configuration clock and the FIFO read clock.
- i_rstn  in  1  asynchronous, active-low reset.
- i_enable  in  1  level; run the sequence while high.
- o_cfg_init  out  1  one-cycle pulse that starts camera register configuration.
- i_cfg_done  in  1  configuration done flag.
- i_sof  in  1  camera SOF pulse from the pclk domain; asynchronous to i_clk.
- i_obuf_empty  in  1  output FIFO empty.
- o_obuf_rd  out  1  output FIFO read enable.
- i_obuf_data  in  16  output FIFO read data; valid the cycle after o_obuf_rd.
- o_pix_valid  out  1  pixel stream valid.
- i_pix_ready  in  1  downstream ready.
- o_pix_data  out  16  RGB565 pixel.
- o_pix_sof  out  1  qualifies the first pixel of a frame.
- o_pix_eof  out  1  qualifies the last pixel of a frame.
- o_frame_err  out  1  one-cycle pulse on a short or long frame.
- o_state  out  3  current state encoding.
- o_timeout  out  1  sticky watchdog flag.

Behaviour:
- Reset values: every output 0; state IDLE; all counters 0.
- SOF capture:
  - i_sof passes through a 2-flop synchroniser, then rising-edge detect giving sof_evt.
  - The source pulse is at least 1 pclk (41 ns), which covers 5 i_clk cycles.
- States and encodings: IDLE=0, PWRUP=1, CFG=2, CFG_WAIT=3, SKIP=4, ALIGN=5, STREAM=6.
  - IDLE -> PWRUP when i_enable=1.
  - PWRUP counts i_clk cycles; after exactly POWERUP_CYCLES -> CFG.
  - CFG asserts o_cfg_init for exactly 1 cycle -> CFG_WAIT.
  - CFG_WAIT -> SKIP on the first cycle i_cfg_done=1.
  - SKIP counts sof_evt; on the FRAME_SKIP-th event -> ALIGN. If FRAME_SKIP=0, go directly to ALIGN.
  - ALIGN and SKIP issue reads whenever i_obuf_empty=0 and discard the data, which keeps the FIFO drained.
  - ALIGN -> STREAM on the next sof_evt; the pixel count clears to 0.
- i_enable=0 in any state except IDLE:
  - Next state is IDLE.
  - o_pix_valid, o_obuf_rd and o_cfg_init clear next cycle.
  - In-flight read data is dropped.
  - Re-enable always restarts at PWRUP.
- STREAM read rule:
  - o_obuf_rd=1 when i_obuf_empty=0, no read is pending, and the output slot is free (o_pix_valid=0, or o_pix_valid=1 with i_pix_ready=1).
  - Data returned 1 cycle later loads o_pix_data and sets o_pix_valid.
  - Maximum throughput is 1 pixel per 2 cycles.
- Output hold: while o_pix_valid=1 and i_pix_ready=0, o_pix_data, o_pix_sof and o_pix_eof hold stable.
- Pixel counting:
  - The counter (width clog2(FRAME_PIXELS+1)) increments on each pixel loaded into the output register.
  - o_pix_sof=1 on pixel index 0.
  - o_pix_eof=1 on index FRAME_PIXELS-1; the count then saturates at FRAME_PIXELS.
- Long frame: pixels arriving while count==FRAME_PIXELS are read and dropped, never presented, and pulse o_frame_err once per frame.
- sof_evt in STREAM:
  - If count!=0 and count!=FRAME_PIXELS (short frame), pulse o_frame_err.
  - In all cases the count resets to 0, so the next pixel carries o_pix_sof.
  - A pixel already held in the output register is still delivered unchanged.
- Simultaneous sof_evt and pixel load in the same cycle: the sof is applied first, so the loaded pixel is index 0.

Optional Feature:
- Macro SEQ_TIMEOUT_EN.
- Defined:
  - A watchdog counts cycles spent in CFG_WAIT, SKIP or ALIGN, and resets on every state change or sof_evt.
  - On reaching TIMEOUT_CYCLES: o_timeout is set (sticky until reset) and the state returns to PWRUP.
- Not defined: no watchdog logic; o_timeout is tied to 0; those states wait indefinitely.

Test Plan:
(bench parameters: POWERUP_CYCLES=10, FRAME_SKIP=2, FRAME_PIXELS=16)
- Bring-up: i_enable=1 at cycle 0 -> o_cfg_init pulses exactly at cycle 11 (1 cycle wide); i_cfg_done at cycle 20 -> state=4 at cycle 21; 2 sof pulses -> state=5; 3rd sof -> state=6.
- Normal frame: 16 pixels 0x0000..0x000F via FIFO, i_pix_ready=1 -> 16 beats in order; o_pix_sof on 0x0000, o_pix_eof on 0x000F; o_frame_err stays 0.
- Backpressure: i_pix_ready toggled randomly -> no loss or duplication; data and flags stable while stalled; o_obuf_rd never asserts with the slot full.
- Short/long frames: sof after 10 pixels -> o_frame_err pulse; next pixel has o_pix_sof. 20 pixels in one frame -> only 16 presented, 4 dropped, one o_frame_err pulse.
- Reset and disable: i_rstn low mid-STREAM -> all outputs 0 asynchronously. i_enable=0 mid-STREAM -> state=0 next cycle; re-enable -> PWRUP and a fresh o_cfg_init.
- SEQ_TIMEOUT_EN with TIMEOUT_CYCLES=50: i_cfg_done held at 0 -> o_timeout=1 at 50 cycles in CFG_WAIT, state=1. Without the macro -> state stays 3 and o_timeout=0.
